// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: receive side of a 4-slot TDM link.
// Locks onto the frame_sync marker at slot 0, flywheels through up to
// MISS_MAX-1 missing markers, and steers beats into four channel outputs.
// A completed frame is presented on y0..y3 with a one-cycle frame_valid.
// Optional build macro TDM_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module tdm_demux_1to4 #(
  parameter int WIDTH    = 8,
  parameter int MISS_MAX = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err,
`ifdef TDM_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic [1:0]       slot
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Threshold widened to match the miss counter plus one.
  localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);

  state_t           state;
  logic [2:0]       miss_cnt;
  logic [WIDTH-1:0] shadow0;
  logic [WIDTH-1:0] shadow1;
  logic [WIDTH-1:0] shadow2;
  logic             miss_ok;

  // A missing marker is tolerated while the run of misses stays below MISS_MAX.
  assign miss_ok = (({1'b0, miss_cnt} + 4'd1) < MISS_LIM);

  // Slot tracking, frame assembly and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      miss_cnt    <= 3'd0;
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      slot        <= 2'd0;
`ifdef TDM_FRAME_CNT_EN
      frame_cnt   <= 16'd0;
`endif
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              shadow0  <= din;
              slot     <= 2'd1;
              miss_cnt <= 3'd0;
              state    <= LOCKED;
              locked   <= 1'b1;
            end
          end
          LOCKED: begin
            if (slot == 2'd0) begin
              if (frame_sync) begin
                shadow0  <= din;
                miss_cnt <= 3'd0;
                slot     <= 2'd1;
              end else if (miss_ok) begin
                // Flywheel: assume the marker was lost, keep the beat as slot 0.
                shadow0  <= din;
                miss_cnt <= miss_cnt + 3'd1;
                slot     <= 2'd1;
              end else begin
                state    <= HUNT;
                locked   <= 1'b0;
                slot     <= 2'd0;
                miss_cnt <= 3'd0;
              end
            end else if (frame_sync) begin
              // Marker in the wrong slot: drop the partial frame and realign.
              sync_err <= 1'b1;
              shadow0  <= din;
              slot     <= 2'd1;
              miss_cnt <= 3'd0;
            end else begin
              case (slot)
                2'd1:    shadow1 <= din;
                2'd2:    shadow2 <= din;
                default: begin
                  y0          <= shadow0;
                  y1          <= shadow1;
                  y2          <= shadow2;
                  y3          <= din;
                  frame_valid <= 1'b1;
`ifdef TDM_FRAME_CNT_EN
                  frame_cnt   <= frame_cnt + 16'd1;
`endif
                end
              endcase
              slot <= slot + 2'd1;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            slot   <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed self-checking bench for tdm_demux_1to4 (WIDTH=8, MISS_MAX=2).
module tb_tdm_demux_1to4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] y0, y1, y2, y3;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;
  logic [1:0] slot;
`ifdef TDM_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int tests_run;
  int tests_failed;

  tdm_demux_1to4 #(.WIDTH(8), .MISS_MAX(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .din_valid(din_valid),
    .frame_sync(frame_sync),
    .y0(y0),
    .y1(y1),
    .y2(y2),
    .y3(y3),
    .frame_valid(frame_valid),
    .locked(locked),
    .sync_err(sync_err),
`ifdef TDM_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .slot(slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, ".y0"}, 32'(y0), 32'(e0));
    chk({tag, ".y1"}, 32'(y1), 32'(e1));
    chk({tag, ".y2"}, 32'(y2), 32'(e2));
    chk({tag, ".y3"}, 32'(y3), 32'(e3));
  endtask

  task automatic beat(input logic [7:0] d, input logic s);
    @(negedge clk);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    din          = 8'h00;
    din_valid    = 1'b0;
    frame_sync   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_y("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset.fv", 32'(frame_valid), 32'd0);
    chk("reset.locked", 32'(locked), 32'd0);
    chk("reset.sync_err", 32'(sync_err), 32'd0);
    chk("reset.slot", 32'(slot), 32'd0);
`ifdef TDM_FRAME_CNT_EN
    chk("reset.cnt", 32'(frame_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Lock and basic frame
    beat(8'hA5, 1'b1);
    chk("basic.locked", 32'(locked), 32'd1);
    chk("basic.slot1", 32'(slot), 32'd1);
    beat(8'h3C, 1'b0);
    chk("basic.slot2", 32'(slot), 32'd2);
    beat(8'h0F, 1'b0);
    chk("basic.slot3", 32'(slot), 32'd3);
    chk("basic.fv_pre", 32'(frame_valid), 32'd0);
    beat(8'hF0, 1'b0);
    chk("basic.fv", 32'(frame_valid), 32'd1);
    chk_y("basic", 8'hA5, 8'h3C, 8'h0F, 8'hF0);
    chk("basic.slot0", 32'(slot), 32'd0);
    idle();
    chk("basic.fv_pulse", 32'(frame_valid), 32'd0);
    chk_y("basic.hold", 8'hA5, 8'h3C, 8'h0F, 8'hF0);

    // Hunt discard
    do_reset();
    beat(8'h11, 1'b0);
    chk("hunt.locked", 32'(locked), 32'd0);
    chk("hunt.slot", 32'(slot), 32'd0);
    beat(8'h22, 1'b0);
    chk("hunt.locked2", 32'(locked), 32'd0);
    beat(8'h01, 1'b1);
    chk("hunt.lock", 32'(locked), 32'd1);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    chk("hunt.fv_pre", 32'(frame_valid), 32'd0);
    beat(8'h04, 1'b0);
    chk("hunt.fv", 32'(frame_valid), 32'd1);
    chk_y("hunt", 8'h01, 8'h02, 8'h03, 8'h04);

    // Flywheel through one missing marker, then lose lock on the second
    beat(8'h10, 1'b0);
    chk("fly.locked", 32'(locked), 32'd1);
    chk("fly.slot", 32'(slot), 32'd1);
    beat(8'h20, 1'b0);
    beat(8'h30, 1'b0);
    beat(8'h40, 1'b0);
    chk("fly.fv", 32'(frame_valid), 32'd1);
    chk_y("fly", 8'h10, 8'h20, 8'h30, 8'h40);
    beat(8'h55, 1'b0);
    chk("fly.unlock", 32'(locked), 32'd0);
    chk("fly.slot_hunt", 32'(slot), 32'd0);
    chk("fly.fv_off", 32'(frame_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      beat(8'h66 + 8'(i), 1'b0);
      chk("fly.no_fv", 32'(frame_valid), 32'd0);
      chk("fly.still_hunt", 32'(locked), 32'd0);
    end
    chk_y("fly.hold", 8'h10, 8'h20, 8'h30, 8'h40);

    // Misplaced sync
    beat(8'h01, 1'b1);
    beat(8'h02, 1'b0);
    chk("mis.no_err", 32'(sync_err), 32'd0);
    beat(8'h77, 1'b1);
    chk("mis.err", 32'(sync_err), 32'd1);
    chk("mis.slot", 32'(slot), 32'd1);
    chk("mis.locked", 32'(locked), 32'd1);
    beat(8'h88, 1'b0);
    chk("mis.err_pulse", 32'(sync_err), 32'd0);
    beat(8'h99, 1'b0);
    chk("mis.fv_pre", 32'(frame_valid), 32'd0);
    chk_y("mis.pre", 8'h10, 8'h20, 8'h30, 8'h40);
    beat(8'hAA, 1'b0);
    chk("mis.fv", 32'(frame_valid), 32'd1);
    chk_y("mis", 8'h77, 8'h88, 8'h99, 8'hAA);

    // Gapped valid: slot frozen and no strobe during gaps
    beat(8'hC1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < 3; g++) begin
        idle();
        chk("gap.slot", 32'(slot), 32'(k + 1));
        chk("gap.fv", 32'(frame_valid), 32'd0);
      end
      beat(8'hC2 + 8'(k), 1'b0);
    end
    chk("gap.fv_end", 32'(frame_valid), 32'd1);
    chk_y("gap", 8'hC1, 8'hC2, 8'hC3, 8'hC4);

    // Back-to-back frames, then reset mid-frame
    do_reset();
    chk_y("b2b.reset", 8'h00, 8'h00, 8'h00, 8'h00);
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 4; s++) begin
        beat(8'hD0 + 8'(16 * f) + 8'(s), (s == 0));
        chk("b2b.fv", 32'(frame_valid), 32'(s == 3));
      end
    end
    chk_y("b2b", 8'hF0, 8'hF1, 8'hF2, 8'hF3);
`ifdef TDM_FRAME_CNT_EN
    chk("b2b.cnt", 32'(frame_cnt), 32'd3);
`endif
    beat(8'h5A, 1'b1);
    beat(8'h5B, 1'b0);
    chk("mid.slot", 32'(slot), 32'd2);
    @(negedge clk);
    din_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk_y("mid", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("mid.fv", 32'(frame_valid), 32'd0);
    chk("mid.locked", 32'(locked), 32'd0);
    chk("mid.slot0", 32'(slot), 32'd0);
`ifdef TDM_FRAME_CNT_EN
    chk("mid.cnt", 32'(frame_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    beat(8'h5C, 1'b0);
    beat(8'h5D, 1'b0);
    chk("mid.after_fv", 32'(frame_valid), 32'd0);
    chk("mid.after_locked", 32'(locked), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1to4.md
Name: tdm_demux_1to4

Overview:
- Receive end of a 4-slot time-division-multiplexed link. The transmit end is a 4:1 mux driven by a 2-bit slot counter.
- Tracks slot position from a frame-sync marker and steers each valid beat into one of four channel registers.
- Presents a complete frame on four parallel outputs with a one-cycle frame_valid strobe.
- Sits after the link serialiser; feeds per-channel consumers.

Parameters:
- WIDTH, 8, data width of each beat and of each channel output.
- MISS_MAX, 2, consecutive missing frame_sync markers at slot 0 tolerated before lock is dropped (legal range 1..7).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  TDM data beat.
- din_valid  input  1  din and frame_sync are qualified this cycle.
- frame_sync  input  1  marks the current beat as slot 0; ignored when din_valid=0.
- y0, y1, y2, y3  output  WIDTH  channel 0..3 data of the last completed frame.
- frame_valid  output  1  one-cycle pulse when y0..y3 are updated.
- locked  output  1  block is in LOCKED state.
- sync_err  output  1  one-cycle pulse when frame_sync arrives at slot 1..3 while locked.
- slot  output  2  slot index expected for the next valid beat.

Behaviour:
- Reset (async assert, sync release): y0..y3=0, frame_valid=0, locked=0, sync_err=0, slot=0, miss counter=0, shadow registers=0, state=HUNT.
- Only cycles with din_valid=1 are beats. Idle cycles change nothing except clearing the frame_valid/sync_err pulses.
- HUNT state:
  - Beats without frame_sync are discarded.
  - A beat with frame_sync is stored as shadow[0]; slot<=1; state<=LOCKED.
  - locked goes to 1 on the same edge.
- LOCKED state, beat at slot 0:
  - frame_sync=1: store to shadow[0], miss counter<=0, slot<=1.
  - frame_sync=0 with miss counter+1 < MISS_MAX: flywheel. Store as slot 0, increment miss counter, slot<=1.
  - frame_sync=0 with miss counter+1 = MISS_MAX: discard the beat, state<=HUNT, locked<=0, slot<=0, miss counter<=0.
- LOCKED state, beat at slot 1..3 with frame_sync=1:
  - sync_err pulses for 1 cycle and the partial frame is abandoned (no frame_valid).
  - The beat is stored as shadow[0]; slot<=1; miss counter<=0; stays LOCKED.
- LOCKED state, beat at slot 1..3 without frame_sync: store to shadow[slot], slot<=slot+1 (mod 4).
- Frame completion:
  - Occurs on a slot-3 beat with no sync_err.
  - On that edge: y0..y2<=shadow[0..2], y3<=din, frame_valid<=1 for exactly one cycle, slot wraps to 0.
  - Latency: outputs are valid the cycle after the slot-3 beat.
- y0..y3 hold their values between frames and across loss of lock. Only reset clears them.
- Back-to-back frames with din_valid held high give frame_valid every 4th cycle.
- Reset mid-frame discards the partial frame; no frame_valid is produced for it.
- slot reads 0 whenever the state is HUNT.

Optional Feature:
- Macro: TDM_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt, 16 bits, reset 0.
  - Increments on the same edge that asserts frame_valid; wraps 16'hFFFF->0.
  - Not cleared on loss of lock.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Lock and basic frame:
  - Stimulus: after reset, beats A5(sync),3C,0F,F0 on consecutive cycles.
  - Required: locked=1 after first beat; next cycle y0=A5, y1=3C, y2=0F, y3=F0, frame_valid=1 for one cycle, slot=0.
- Hunt discard:
  - Stimulus: beats 11,22 without sync, then 01(sync),02,03,04.
  - Required: 11/22 dropped; one frame_valid with y0..y3=01,02,03,04.
- Flywheel and lock loss (MISS_MAX=2):
  - Stimulus: one good frame, then a frame with no sync on slot 0 (10,20,30,40), then another slot-0 beat without sync.
  - Required: second frame is output (y0=10, y3=40). Third-frame slot-0 beat gives locked=0 and no further frame_valid until the next sync.
- Misplaced sync:
  - Stimulus: 01(sync),02, then 77(sync),88,99,AA.
  - Required: sync_err pulses once on the 77 beat; the only frame output is 77,88,99,AA.
- Gapped valid:
  - Stimulus: frame beats with din_valid low for 3 cycles between each.
  - Required: same y values as the ungapped case, one frame_valid, slot frozen during gaps.
- Reset mid-frame plus counter (TDM_FRAME_CNT_EN defined):
  - Stimulus: 3 complete frames, then rst_n=0 after the slot-1 beat of the 4th.
  - Required: frame_cnt=3 before reset. Immediately on reset: all outputs 0, frame_cnt=0, no frame_valid.
